ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage. It consumes the decoded operation and operands that the decode stage issues: aluop, reg1, reg2. It executes MULT/MULTU in 2 cycles and DIV/DIVU with a 32-iteration restoring divider. While busy it holds the pipeline through stall_o, then presents a 64-bit {HI,LO} result with a one-cycle write strobe toward the HI/LO register file.

---
 rtl/ex_muldiv.sv | 177 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage: 2-cycle multiply,
// 32-step restoring divide, {HI,LO} result with a one-cycle write strobe.
module ex_muldiv #(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        annul_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        hilo_we_o,
    output logic        busy_o
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = $clog2(DIV_ITER);

    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_ON,
        S_DIVZERO,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       rem_q, quot_q, dvsr_q;
    logic               neg_q_q, neg_r_q;

    logic               is_mul, is_div, is_signed, start, last_iter;
    logic [2*W-1:0]     a_ext, b_ext, prod;
    logic [W-1:0]       abs_a, abs_b;
    logic [W:0]         upper, diff;
    logic [W-1:0]       rem_n, quot_n, rem_fix, quot_fix;

    // Operation decode and accept condition
    always_comb begin
        is_mul    = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
        is_div    = (aluop_i == EXE_DIV_OP)  || (aluop_i == EXE_DIVU_OP);
        is_signed = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_DIV_OP);
        start     = ~rst & valid_i & ~annul_i & (is_mul | is_div) & (state_q == S_IDLE);
        last_iter = (cnt_q == CNT_W'(DIV_ITER - 1));
    end

    // One multiplier serves both signednesses: sign- or zero-extend, keep low 64 bits
    always_comb begin
        a_ext = {{W{is_signed & reg1_i[W-1]}}, reg1_i};
        b_ext = {{W{is_signed & reg2_i[W-1]}}, reg2_i};
        prod  = a_ext * b_ext;
        abs_a = (is_signed & reg1_i[W-1]) ? -reg1_i : reg1_i;
        abs_b = (is_signed & reg2_i[W-1]) ? -reg2_i : reg2_i;
    end

    // Restoring divide step on {rem,quot} shifted left by one
    always_comb begin
        upper = {rem_q, quot_q[W-1]};
        diff  = upper - {1'b0, dvsr_q};
        if (!diff[W]) begin
            rem_n  = diff[W-1:0];
            quot_n = {quot_q[W-2:0], 1'b1};
        end else begin
            rem_n  = upper[W-1:0];
            quot_n = {quot_q[W-2:0], 1'b0};
        end
        quot_fix = neg_q_q ? -quot_n : quot_n;
        rem_fix  = neg_r_q ? -rem_n  : rem_n;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        busy_o    = 1'b0;
        hilo_we_o = 1'b0;
        if (!rst) begin
            busy_o = (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        stall_o = 1'b1;
                        if (is_mul)             state_d = S_MUL;
                        else if (reg2_i == '0)  state_d = S_DIVZERO;
                        else                    state_d = S_DIV_ON;
                    end
                end
                S_MUL, S_DIVZERO: begin
                    if (annul_i) state_d = S_IDLE;
                    else begin
                        stall_o = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DIV_ON: begin
                    if (annul_i) state_d = S_IDLE;
                    else begin
                        stall_o = 1'b1;
                        if (last_iter) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    hilo_we_o = ~annul_i;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: rem/quot double as the product and divide-by-zero holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            {rem_q, quot_q} <= prod;
                        end else if (reg2_i == '0) begin
                            rem_q  <= reg1_i;
                            quot_q <= '1;
                        end else begin
                            rem_q   <= '0;
                            quot_q  <= abs_a;
                            dvsr_q  <= abs_b;
                            neg_q_q <= is_signed & (reg1_i[W-1] ^ reg2_i[W-1]);
                            neg_r_q <= is_signed & reg1_i[W-1];
                            cnt_q   <= '0;
                        end
                    end
                end
                S_MUL, S_DIVZERO: begin
                    if (!annul_i) begin
                        hi_o <= rem_q;
                        lo_o <= quot_q;
                    end
                end
                S_DIV_ON: begin
                    if (!annul_i) begin
                        rem_q  <= rem_n;
                        quot_q <= quot_n;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            hi_o <= rem_fix;
                            lo_o <= quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: latency, results, annul and reset.
module tb_ex_muldiv;

    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_DIV   = 8'b00011010;
    localparam logic [7:0] OP_DIVU  = 8'b00011011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  aluop;
    logic [31:0] reg1, reg2;
    logic        annul;
    logic        stall;
    logic [31:0] hi, lo;
    logic        hilo_we;
    logic        busy;

    int unsigned vectors = 0;
    int unsigned errs    = 0;

    ex_muldiv #(.DIV_ITER(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid),
        .aluop_i   (aluop),
        .reg1_i    (reg1),
        .reg2_i    (reg2),
        .annul_i   (annul),
        .stall_o   (stall),
        .hi_o      (hi),
        .lo_o      (lo),
        .hilo_we_o (hilo_we),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge; inputs are driven here
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Operation already driven in this cycle (T0): check stall profile and result
    task automatic finish_op(input string tag, input int lat,
                             input logic [31:0] ehi, input logic [31:0] elo);
        int bad;
        chk({tag, " stall T0"}, 64'(stall), 64'd1);
        bad = 0;
        for (int k = 1; k < lat; k++) begin
            next();
            reg1 = $urandom;
            reg2 = $urandom;
            #1;
            if (stall !== 1'b1 || hilo_we !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk({tag, " busy window"}, 64'(bad), 64'd0);
        next();
        #1;
        chk({tag, " we"},    64'(hilo_we), 64'd1);
        chk({tag, " stall"}, 64'(stall),   64'd0);
        chk({tag, " hi"},    64'(hi),      64'(ehi));
        chk({tag, " lo"},    64'(lo),      64'(elo));
        next();
        valid = 1'b0;
        aluop = 8'h00;
        #1;
        chk({tag, " we pulse"}, 64'(hilo_we), 64'd0);
        chk({tag, " hold"},     {hi, lo},     {ehi, elo});
        chk({tag, " idle"},     64'(busy),    64'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        next();
        annul = 1'b0;
        valid = 1'b1;
        aluop = op;
        reg1  = a;
        reg2  = b;
        #1;
        finish_op(tag, lat, ehi, elo);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        aluop = 8'h00;
        reg1  = '0;
        reg2  = '0;
        annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("por outputs", {31'd0, stall, hilo_we, busy, hi}, 64'd0);
        chk("por lo", 64'(lo), 64'd0);

        run_op("divu 100/7",      OP_DIVU,  32'd100,        32'd7,          33, 32'd2,        32'd14);
        run_op("div -7/2",        OP_DIV,   32'hFFFFFFF9,   32'd2,          33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div min/-1",      OP_DIV,   32'h80000000,   32'hFFFFFFFF,   33, 32'h0,        32'h80000000);
        run_op("divu by zero",    OP_DIVU,  32'h1234,       32'h0,          2,  32'h1234,     32'hFFFFFFFF);
        run_op("div by zero",     OP_DIV,   32'hFFFFFFF0,   32'h0,          2,  32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op("mult -1*3",       OP_MULT,  32'hFFFFFFFF,   32'd3,          2,  32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("multu max*3",     OP_MULTU, 32'hFFFFFFFF,   32'd3,          2,  32'h2,        32'hFFFFFFFD);
        run_op("mult min*min",    OP_MULT,  32'h80000000,   32'h80000000,   2,  32'h40000000, 32'h0);
        run_op("multu max*max",   OP_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   2,  32'hFFFFFFFE, 32'h00000001);

        // Non-muldiv op, bubble, and annul in IDLE must not start anything
        next();
        valid = 1'b1;
        aluop = 8'h20;
        #1;
        chk("other op stall", 64'(stall), 64'd0);
        next();
        aluop = OP_DIV;
        valid = 1'b0;
        #1;
        chk("other op idle", 64'(busy), 64'd0);
        chk("bubble stall",  64'(stall), 64'd0);
        next();
        valid = 1'b1;
        annul = 1'b1;
        #1;
        chk("annul idle stall", 64'(stall), 64'd0);
        next();
        valid = 1'b0;
        annul = 1'b0;
        #1;
        chk("annul idle busy", 64'(busy), 64'd0);

        // Annul during DONE suppresses the write strobe
        next();
        valid = 1'b1;
        aluop = OP_MULTU;
        reg1  = 32'd5;
        reg2  = 32'd7;
        #1;
        next();
        #1;
        next();
        annul = 1'b1;
        #1;
        chk("annul done we",    64'(hilo_we), 64'd0);
        chk("annul done stall", 64'(stall),   64'd0);
        next();
        annul = 1'b0;
        valid = 1'b0;
        #1;
        chk("annul done idle",  64'(busy), 64'd0);

        run_op("div -100/7",      OP_DIV,   32'hFFFFFF9C,   32'd7,          33, 32'hFFFFFFFE, 32'hFFFFFFF2);
        run_op("div 100/-7",      OP_DIV,   32'd100,        32'hFFFFFFF9,   33, 32'd2,        32'hFFFFFFF2);

        // Annul at divide iteration 10, then an immediate DIVU 9/3
        next();
        valid = 1'b1;
        aluop = OP_DIV;
        reg1  = 32'd1000;
        reg2  = 32'd7;
        #1;
        chk("annul div T0 stall", 64'(stall), 64'd1);
        for (int k = 0; k < 10; k++) next();
        annul = 1'b1;
        #1;
        chk("annul div stall", 64'(stall),   64'd0);
        chk("annul div we",    64'(hilo_we), 64'd0);
        next();
        annul = 1'b0;
        valid = 1'b1;
        aluop = OP_DIVU;
        reg1  = 32'd9;
        reg2  = 32'd3;
        #1;
        chk("annul div hilo kept", {hi, lo}, {32'd2, 32'hFFFFFFF2});
        chk("annul div we after",  64'(hilo_we), 64'd0);
        finish_op("divu 9/3", 33, 32'd0, 32'd3);

        // Reset for two cycles in the middle of a divide (iteration 5)
        next();
        valid = 1'b1;
        aluop = OP_DIVU;
        reg1  = 32'd1000;
        reg2  = 32'd3;
        #1;
        chk("rst div T0 stall", 64'(stall), 64'd1);
        for (int k = 0; k < 6; k++) next();
        rst   = 1'b1;
        valid = 1'b0;
        #1;
        chk("rst cycle1 stall/busy", {stall, busy}, 64'd0);
        next();
        #1;
        chk("rst cycle2 stall/busy/we", {stall, busy, hilo_we}, 64'd0);
        next();
        rst = 1'b0;
        #1;
        chk("post rst ctrl", {stall, busy, hilo_we}, 64'd0);
        chk("post rst hilo", {hi, lo}, 64'd0);
        next();
        #1;
        chk("post rst stays idle", {stall, busy, hilo_we}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
